hpu_ren_sfl: RTL and testbench

// - Speculative free list (SFL) of the rename stage; allocates physical destination registers to decoded insts.
// - Consumer end of the AFL recovery interface: on flush, reloads its free vector from afl_rcov_data_i.
// - Commit-side releases (old rdst) arrive from ROB via update_arat_t, mirroring the AFL update.

---
 rtl/hpu_pkg.sv | 20 ++
 rtl/hpu_sfl_pick.sv | 30 +++
 rtl/hpu_ren_sfl.sv | 128 ++++++++++++
 tb/tb_hpu_ren_sfl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Rename-stage shared types: register-file sizing, ROB commit bundle and SFL grant bundle.
package hpu_pkg;

  localparam int PHY_SR_LEN       = 32;
  localparam int INST_DEC_PARAL   = 2;
  localparam int PHY_SR_INDEX_LEN = $clog2(PHY_SR_LEN);

  typedef struct packed {
    logic                                                en;
    logic [INST_DEC_PARAL-1:0]                           avail;
    logic [INST_DEC_PARAL-1:0][PHY_SR_INDEX_LEN-1:0]     phy_rdst_index;
    logic [INST_DEC_PARAL-1:0][PHY_SR_INDEX_LEN-1:0]     phy_old_rdst_index;
  } update_arat_t;

  typedef struct packed {
    logic                                                ack;
    logic [INST_DEC_PARAL-1:0][PHY_SR_INDEX_LEN-1:0]     phy_rdst_index;
  } sfl_alloc_t;

endpackage

// File: rtl/hpu_sfl_pick.sv
// Finds the ALLOC_PARAL lowest set bits of a free vector, in ascending order; purely combinational.
module hpu_sfl_pick #(
  parameter int PHY_SR_NUM  = 32,
  parameter int ALLOC_PARAL = 2,
  parameter int IDX_W       = 5
) (
  input  logic [PHY_SR_NUM-1:0]              free_vec,
  output logic [ALLOC_PARAL-1:0][IDX_W-1:0]  pick_idx,
  output logic [ALLOC_PARAL-1:0]             pick_vld
);

  always_comb begin
    int found;
    pick_idx = '0;
    pick_vld = '0;
    found    = 0;
    for (int i = 0; i < PHY_SR_NUM; i++) begin
      if (free_vec[i]) begin
        for (int k = 0; k < ALLOC_PARAL; k++) begin
          if (found == k) begin
            pick_idx[k] = IDX_W'(i);
            pick_vld[k] = 1'b1;
          end
        end
        found++;
      end
    end
  end

endmodule

// File: rtl/hpu_ren_sfl.sv
// Speculative free list: all-or-nothing rdst allocation, commit releases, flush reload from the AFL.
// Define HPU_SFL_FREE_CNT_EN for a registered free counter driving sfl__free_cnt_o and the sufficiency check.
module hpu_ren_sfl
  import hpu_pkg::*;
#(
  parameter int PHY_SR_NUM  = PHY_SR_LEN,
  parameter int ALLOC_PARAL = INST_DEC_PARAL,
  parameter int IDX_W       = $clog2(PHY_SR_NUM)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              id__alloc_req_i,
  input  logic [ALLOC_PARAL-1:0]            id__alloc_vld_i,
  output logic                              sfl__alloc_ack_o,
  output logic [ALLOC_PARAL-1:0][IDX_W-1:0] sfl__phy_rdst_index_o,
  input  update_arat_t                      rob_id__update_arat_i,
  input  logic                              afl_rcov_en_i,
  input  logic [PHY_SR_NUM-1:0]             afl_rcov_data_i,
  output logic [IDX_W:0]                    sfl__free_cnt_o
);

  localparam int CNT_W = IDX_W + 1;

  logic [PHY_SR_NUM-1:0]              free_q;
  logic [PHY_SR_NUM-1:0]              free_nxt;
  logic [ALLOC_PARAL-1:0][IDX_W-1:0]  pick_idx;
  logic [ALLOC_PARAL-1:0]             pick_vld;
  logic [ALLOC_PARAL-1:0][IDX_W-1:0]  rdst_idx;
  logic                               enough;
  logic                               grant;
  logic [INST_DEC_PARAL-1:0]          rel_vec;

  hpu_sfl_pick #(
    .PHY_SR_NUM  (PHY_SR_NUM),
    .ALLOC_PARAL (ALLOC_PARAL),
    .IDX_W       (IDX_W)
  ) u_pick (
    .free_vec (free_q),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // Slot k takes the n-th pick, where n counts requesting slots below k.
  always_comb begin
    int n;
    rdst_idx = '0;
    n        = 0;
    for (int k = 0; k < ALLOC_PARAL; k++) begin
      if (id__alloc_vld_i[k]) begin
        for (int j = 0; j < ALLOC_PARAL; j++) begin
          if (n == j) rdst_idx[k] = pick_idx[j];
        end
        n++;
      end
    end
  end

  assign rel_vec = rob_id__update_arat_i.avail & {INST_DEC_PARAL{rob_id__update_arat_i.en}};
  assign grant   = id__alloc_req_i & ~afl_rcov_en_i & enough & ~rst_i;

  assign sfl__alloc_ack_o      = grant;
  assign sfl__phy_rdst_index_o = rst_i ? '0 : rdst_idx;

  // Releases are applied after the grant so a freed register only becomes grantable next cycle.
  always_comb begin
    free_nxt = afl_rcov_en_i ? afl_rcov_data_i : free_q;
    if (grant) begin
      for (int k = 0; k < ALLOC_PARAL; k++) begin
        if (id__alloc_vld_i[k]) free_nxt[rdst_idx[k]] = 1'b0;
      end
    end
    for (int i = 0; i < INST_DEC_PARAL; i++) begin
      if (rel_vec[i]) begin
        free_nxt[rob_id__update_arat_i.phy_old_rdst_index[i]] = 1'b1;
        if (afl_rcov_en_i) free_nxt[rob_id__update_arat_i.phy_rdst_index[i]] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) free_q <= '1;
    else       free_q <= free_nxt;
  end

`ifdef HPU_SFL_FREE_CNT_EN
  logic [CNT_W-1:0] free_cnt_q;
  logic [CNT_W-1:0] free_cnt_nxt;
  logic [CNT_W-1:0] need_cnt;

  assign need_cnt = CNT_W'($countones(id__alloc_vld_i));
  assign enough   = free_cnt_q >= need_cnt;

  always_comb begin
    if (afl_rcov_en_i) free_cnt_nxt = CNT_W'($countones(free_nxt));
    else               free_cnt_nxt = free_cnt_q - (grant ? need_cnt : '0)
                                      + CNT_W'($countones(rel_vec));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) free_cnt_q <= CNT_W'(PHY_SR_NUM);
    else       free_cnt_q <= free_cnt_nxt;
  end

  assign sfl__free_cnt_o = free_cnt_q;
`else
  assign enough          = $countones(free_q) >= $countones(id__alloc_vld_i);
  assign sfl__free_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && grant) begin
      for (int k = 0; k < ALLOC_PARAL; k++) begin
        if (id__alloc_vld_i[k]) begin
          assert (free_q[rdst_idx[k]])
            else $error("sfl granted busy index %0d on slot %0d", rdst_idx[k], k);
          for (int j = 0; j < k; j++) begin
            if (id__alloc_vld_i[j])
              assert (rdst_idx[j] != rdst_idx[k])
                else $error("sfl duplicate index %0d on slots %0d/%0d", rdst_idx[k], j, k);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_hpu_ren_sfl.sv
// Directed plus random bench for hpu_ren_sfl, checked against a free-set reference model.
module tb_hpu_ren_sfl;
  import hpu_pkg::*;

  localparam int N = PHY_SR_LEN;
  localparam int P = INST_DEC_PARAL;
  localparam int W = PHY_SR_INDEX_LEN;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req;
  logic [P-1:0]          vld;
  logic                  ack;
  logic [P-1:0][W-1:0]   idx;
  update_arat_t          upd;
  logic                  fen;
  logic [N-1:0]          fdata;
  logic [W:0]            cnt;

  int checks = 0;
  int errors = 0;

  bit                    mfree [N];
  logic                  last_ack;
  logic [P-1:0][W-1:0]   last_idx;

  always #5 clk = ~clk;

  hpu_ren_sfl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .id__alloc_req_i       (req),
    .id__alloc_vld_i       (vld),
    .sfl__alloc_ack_o      (ack),
    .sfl__phy_rdst_index_o (idx),
    .rob_id__update_arat_i (upd),
    .afl_rcov_en_i         (fen),
    .afl_rcov_data_i       (fdata),
    .sfl__free_cnt_o       (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mfree[i];
    return v;
  endfunction

  function automatic int model_free_cnt();
    int c = 0;
    foreach (mfree[i]) if (mfree[i]) c++;
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; vld = '0; upd = '0; fen = 1'b0; fdata = '0;
    @(posedge clk); #1;
    chk("rst_ack", ack, 0);
    chk("rst_idx", idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (mfree[i]) mfree[i] = 1'b1;
    chk("rst_free", dut.free_q, model_vec());
`ifdef HPU_SFL_FREE_CNT_EN
    chk("rst_cnt", cnt, N);
`else
    chk("rst_cnt", cnt, 0);
`endif
  endtask

  // One cycle: drive, compare the combinational grant with the model, advance the model, compare state.
  task automatic step(input logic r, input logic [P-1:0] v, input logic cen, input logic [P-1:0] av,
                      input int old0, input int old1, input int new0, input int new1,
                      input logic fe, input logic [N-1:0] fd);
    int  free_list[$];
    int  need, n;
    bit  exp_ack;
    int  exp_idx [P];
    int  olds [P];
    int  news [P];
    req = r; vld = v; fen = fe; fdata = fd;
    upd = '0;
    upd.en = cen; upd.avail = av;
    upd.phy_old_rdst_index[0] = W'(old0); upd.phy_old_rdst_index[1] = W'(old1);
    upd.phy_rdst_index[0]     = W'(new0); upd.phy_rdst_index[1]     = W'(new1);
    olds[0] = old0; olds[1] = old1; news[0] = new0; news[1] = new1;
    #3;
    foreach (mfree[i]) if (mfree[i]) free_list.push_back(i);
    need = 0;
    for (int k = 0; k < P; k++) if (v[k]) need++;
    exp_ack = r && !fe && (free_list.size() >= need);
    n = 0;
    for (int k = 0; k < P; k++) begin
      exp_idx[k] = 0;
      if (v[k]) begin
        if (n < free_list.size()) exp_idx[k] = free_list[n];
        n++;
      end
    end
    chk("ack", ack, exp_ack);
    if (exp_ack) for (int k = 0; k < P; k++) chk("idx", idx[k], exp_idx[k]);
`ifdef HPU_SFL_FREE_CNT_EN
    chk("cnt", cnt, model_free_cnt());
`else
    chk("cnt", cnt, 0);
`endif
    last_ack = ack;
    last_idx = idx;
    if (fe) begin
      for (int i = 0; i < N; i++) mfree[i] = fd[i];
      for (int i = 0; i < P; i++) if (cen && av[i]) begin
        mfree[olds[i]] = 1'b1;
        mfree[news[i]] = 1'b0;
      end
    end else begin
      if (exp_ack) for (int k = 0; k < P; k++) if (v[k]) mfree[exp_idx[k]] = 1'b0;
      for (int i = 0; i < P; i++) if (cen && av[i]) mfree[olds[i]] = 1'b1;
    end
    @(posedge clk); #1;
    chk("free_q", dut.free_q, model_vec());
  endtask

  task automatic idle_step(input logic r, input logic [P-1:0] v);
    step(r, v, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, '0);
  endtask

  initial begin
    logic [N-1:0] d;
    int busy[$];
    int a, b;

    do_reset();

    // two-wide group on a fresh list, then the next two
    idle_step(1'b1, 2'b11);
    chk("t1_ack", last_ack, 1);
    chk("t1_idx0", last_idx[0], 0);
    chk("t1_idx1", last_idx[1], 1);
    idle_step(1'b1, 2'b11);
    chk("t2_idx0", last_idx[0], 2);
    chk("t2_idx1", last_idx[1], 3);

    // only slot 1 requests
    do_reset();
    idle_step(1'b1, 2'b10);
    chk("t3_idx0", last_idx[0], 0);
    chk("t3_idx1", last_idx[1], 0);
    chk("t3_free", dut.free_q, 32'hFFFF_FFFE);

    // drain to a single free entry, a two-wide group stalls while reg 0 is released
    for (int i = 0; i < 15; i++) idle_step(1'b1, 2'b11);
    chk("t4_one_left", dut.free_q, 32'h8000_0000);
    step(1'b1, 2'b11, 1'b1, 2'b01, 0, 0, 0, 0, 1'b0, '0);
    chk("t4_stall", last_ack, 0);
    idle_step(1'b1, 2'b11);
    chk("t4_ack", last_ack, 1);
    chk("t4_idx0", last_idx[0], 0);
    chk("t4_idx1", last_idx[1], 31);

    // a released register is not grantable in its release cycle
    step(1'b0, 2'b00, 1'b1, 2'b11, 10, 11, 0, 0, 1'b0, '0);
    step(1'b1, 2'b11, 1'b1, 2'b01, 5, 0, 0, 0, 1'b0, '0);
    chk("t5_idx0", last_idx[0], 10);
    chk("t5_idx1", last_idx[1], 11);
    idle_step(1'b1, 2'b01);
    chk("t5_next", last_idx[0], 5);

    // flush blocks allocation and reloads the vector
    d = '1; d[3] = 1'b0; d[7] = 1'b0;
    step(1'b1, 2'b11, 1'b0, 2'b00, 0, 0, 0, 0, 1'b1, d);
    chk("t6_ack", last_ack, 0);
    chk("t6_free", dut.free_q, d);

    // flush with a same-cycle commit on top
    d = '1; d[9] = 1'b0;
    step(1'b0, 2'b00, 1'b1, 2'b01, 9, 0, 3, 0, 1'b1, d);
    chk("t7_free", dut.free_q, 32'hFFFF_FFF7);

    // random traffic with legal releases of busy registers
    for (int c = 0; c < 400; c++) begin
      logic [P-1:0] av;
      busy.delete();
      foreach (mfree[i]) if (!mfree[i]) busy.push_back(i);
      av = '0; a = 0; b = 0;
      if (busy.size() >= 1 && $urandom_range(0, 2) != 0) begin
        a = busy[$urandom_range(0, busy.size() - 1)];
        av[0] = 1'b1;
      end
      if (busy.size() >= 2 && $urandom_range(0, 2) == 0) begin
        do b = busy[$urandom_range(0, busy.size() - 1)]; while (av[0] && b == a);
        av[1] = 1'b1;
      end
      if ($urandom_range(0, 19) == 0)
        step(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), |av, av, a, b,
             $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'b1, N'($urandom));
      else
        step(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), |av, av, a, b,
             0, 0, 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
